// File: rtl/controle_operacional.sv
// Moore sequencer for the 4-bit A/B accumulate datapath: one command per start/done handshake.
// Optional feature macro: CONTROLE_ABORT_EN adds a synchronous abort_i that cancels LOAD/EXEC.
module controle_operacional #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       cmd_i,
    input  logic [1:0]       op_i,
    input  logic [CNT_W-1:0] count_i,
`ifdef CONTROLE_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             selA_o,
    output logic             wrA_o,
    output logic             wrB_o,
    output logic [1:0]       aluOp_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] CMD_LDA  = 2'b00;
    localparam logic [1:0] CMD_LDB  = 2'b01;
    localparam logic [1:0] CMD_LDAB = 2'b10;
    localparam logic [1:0] CMD_EXEC = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_a, wr_a, wr_b;
    logic             abort_w;

`ifdef CONTROLE_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cmd_q   <= 2'b00;
            op_q    <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sel_a   = 1'b0;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cmd_d = cmd_i;
                    op_d  = op_i;
                    cnt_d = count_i;
                    if (cmd_i != CMD_EXEC)
                        state_d = LOAD;
                    else if (count_i != '0)
                        state_d = EXEC;
                    else
                        state_d = DONE;
                end
            end
            LOAD: begin
                sel_a   = (cmd_q == CMD_LDA) || (cmd_q == CMD_LDAB);
                wr_a    = (cmd_q == CMD_LDA) || (cmd_q == CMD_LDAB);
                wr_b    = (cmd_q == CMD_LDB) || (cmd_q == CMD_LDAB);
                state_d = DONE;
            end
            EXEC: begin
                wr_a  = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                // The cycle holding counter=1 performs the final write.
                if (cnt_q == CNT_W'(1))
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort outranks counter expiry and suppresses the write of this very cycle.
        if (abort_w && (state_q == LOAD || state_q == EXEC)) begin
            wr_a    = 1'b0;
            wr_b    = 1'b0;
            state_d = IDLE;
        end
    end

    assign selA_o  = sel_a;
    assign wrA_o   = wr_a;
    assign wrB_o   = wr_b;
    assign aluOp_o = op_q;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);

endmodule

// File: tb/tb_controle_operacional.sv
// Directed bench for controle_operacional with a small A/B/ALU datapath model (op 10 = add).
// Build with CONTROLE_ABORT_EN defined to also exercise the abort path.
module tb_controle_operacional;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [1:0] cmd_i;
    logic [1:0] op_i;
    logic [3:0] count_i;
    logic       abort_i;
    logic       selA_o, wrA_o, wrB_o, busy_o, done_o;
    logic [1:0] aluOp_o;

    int n_checks = 0;
    int n_fail   = 0;

    // {selA, wrA, wrB, aluOp[1:0], busy, done}
    logic [6:0] obs;
    assign obs = {selA_o, wrA_o, wrB_o, aluOp_o, busy_o, done_o};

    controle_operacional #(.CNT_W(4)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .cmd_i   (cmd_i),
        .op_i    (op_i),
        .count_i (count_i),
`ifdef CONTROLE_ABORT_EN
        .abort_i (abort_i),
`endif
        .selA_o  (selA_o),
        .wrA_o   (wrA_o),
        .wrB_o   (wrB_o),
        .aluOp_o (aluOp_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference datapath driven by the controller outputs.
    logic [3:0] ext_a, ext_b, reg_a, reg_b, alu_y;
    always_comb begin
        case (aluOp_o)
            2'b00:   alu_y = reg_a & reg_b;
            2'b01:   alu_y = reg_a | reg_b;
            2'b10:   alu_y = reg_a + reg_b;
            default: alu_y = reg_a - reg_b;
        endcase
    end
    always @(posedge clk_i) begin
        if (wrA_o) reg_a <= selA_o ? ext_a : alu_y;
        if (wrB_o) reg_b <= ext_b;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one command for a single edge, then withdraw start.
    task automatic issue(input logic [1:0] c, input logic [1:0] o, input logic [3:0] n);
        start_i = 1'b1;
        cmd_i   = c;
        op_i    = o;
        count_i = n;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b0000000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b exp %b", obs, 7'b0000000);
        end
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        tick();
        n_checks++;
        if (obs !== 7'b0000000) begin
            n_fail++;
            $display("FAIL reset_release: got %b exp %b", obs, 7'b0000000);
        end
    endtask

    task automatic test_lda();
        logic [6:0] exp_seq [3];
        exp_seq = '{7'b1100110, 7'b0000111, 7'b0000100};
        ext_a = 4'd9;
        issue(2'b00, 2'b01, 4'd0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL lda_cycle%0d: got %b exp %b", i, obs, exp_seq[i]);
            end
            tick();
        end
        n_checks++;
        if (reg_a !== 4'd9) begin
            n_fail++;
            $display("FAIL lda_reg_a: got %0d exp %0d", reg_a, 9);
        end
    endtask

    task automatic test_ldab_ldb();
        logic [6:0] exp_ab [3];
        logic [6:0] exp_b  [3];
        exp_ab = '{7'b1110010, 7'b0000011, 7'b0000000};
        exp_b  = '{7'b0011110, 7'b0001111, 7'b0001100};
        ext_a = 4'd1;
        ext_b = 4'd6;
        issue(2'b10, 2'b00, 4'd0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs !== exp_ab[i]) begin
                n_fail++;
                $display("FAIL ldab_cycle%0d: got %b exp %b", i, obs, exp_ab[i]);
            end
            tick();
        end
        ext_a = 4'd7;
        ext_b = 4'd1;
        issue(2'b01, 2'b11, 4'd0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs !== exp_b[i]) begin
                n_fail++;
                $display("FAIL ldb_cycle%0d: got %b exp %b", i, obs, exp_b[i]);
            end
            tick();
        end
        n_checks++;
        if ({reg_a, reg_b} !== {4'd1, 4'd1}) begin
            n_fail++;
            $display("FAIL ldab_ldb_regs: got a=%0d b=%0d exp a=1 b=1", reg_a, reg_b);
        end
    endtask

    task automatic test_exec();
        issue(2'b11, 2'b10, 4'd3);
        // Inputs changing after acceptance must not disturb the command in flight.
        cmd_i   = 2'b00;
        op_i    = 2'b01;
        count_i = 4'd7;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs !== 7'b0101010) begin
                n_fail++;
                $display("FAIL exec_write%0d: got %b exp %b", i, obs, 7'b0101010);
            end
            tick();
        end
        n_checks++;
        if (obs !== 7'b0001011) begin
            n_fail++;
            $display("FAIL exec_done: got %b exp %b", obs, 7'b0001011);
        end
        tick();
        n_checks++;
        if (obs !== 7'b0001000) begin
            n_fail++;
            $display("FAIL exec_idle: got %b exp %b", obs, 7'b0001000);
        end
        n_checks++;
        if (reg_a !== 4'd4) begin
            n_fail++;
            $display("FAIL exec_result: got %0d exp %0d", reg_a, 4);
        end
    endtask

    task automatic test_exec_zero();
        issue(2'b11, 2'b01, 4'd0);
        n_checks++;
        if (obs !== 7'b0000111) begin
            n_fail++;
            $display("FAIL exec0_done: got %b exp %b", obs, 7'b0000111);
        end
        tick();
        n_checks++;
        if (obs !== 7'b0000100) begin
            n_fail++;
            $display("FAIL exec0_idle: got %b exp %b", obs, 7'b0000100);
        end
        n_checks++;
        if (reg_a !== 4'd4) begin
            n_fail++;
            $display("FAIL exec0_no_write: got %0d exp %0d", reg_a, 4);
        end
    endtask

    task automatic test_exec_max();
        int writes;
        writes = 0;
        issue(2'b11, 2'b10, 4'd15);
        for (int i = 0; i < 20 && busy_o && !done_o; i++) begin
            if (obs === 7'b0101010) writes++;
            tick();
        end
        n_checks++;
        if (writes != 15) begin
            n_fail++;
            $display("FAIL exec15_writes: got %0d exp %0d", writes, 15);
        end
        n_checks++;
        if (obs !== 7'b0001011) begin
            n_fail++;
            $display("FAIL exec15_done: got %b exp %b", obs, 7'b0001011);
        end
        tick();
        // 4 + 15*1 wraps to 3 in four bits.
        n_checks++;
        if (reg_a !== 4'd3) begin
            n_fail++;
            $display("FAIL exec15_result: got %0d exp %0d", reg_a, 3);
        end
    endtask

    task automatic test_start_held();
        logic [6:0] exp_seq [6];
        exp_seq = '{7'b1100010, 7'b0000011, 7'b0000000,
                    7'b1101110, 7'b0001111, 7'b0001100};
        start_i = 1'b1;
        cmd_i   = 2'b00;
        op_i    = 2'b00;
        count_i = 4'd0;
        tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL held_cycle%0d: got %b exp %b", i, obs, exp_seq[i]);
            end
            if (i == 2) op_i = 2'b11;
            if (i == 3) start_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        issue(2'b11, 2'b10, 4'd5);
        tick();
        #2;
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b0000000) begin
            n_fail++;
            $display("FAIL reset_mid: got %b exp %b", obs, 7'b0000000);
        end
        tick();
        reset_i = 1'b0;
        tick();
        n_checks++;
        if (obs !== 7'b0000000) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got %b exp %b", obs, 7'b0000000);
        end
    endtask

`ifdef CONTROLE_ABORT_EN
    task automatic test_abort();
        issue(2'b11, 2'b10, 4'd5);
        n_checks++;
        if (obs !== 7'b0101010) begin
            n_fail++;
            $display("FAIL abort_first: got %b exp %b", obs, 7'b0101010);
        end
        tick();
        abort_i = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b0001010) begin
            n_fail++;
            $display("FAIL abort_gate: got %b exp %b", obs, 7'b0001010);
        end
        tick();
        abort_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs !== 7'b0001000) begin
                n_fail++;
                $display("FAIL abort_idle%0d: got %b exp %b", i, obs, 7'b0001000);
            end
            tick();
        end
    endtask
`endif

    initial begin
        start_i = 1'b0;
        cmd_i   = 2'b00;
        op_i    = 2'b00;
        count_i = 4'd0;
        abort_i = 1'b0;
        ext_a   = 4'd0;
        ext_b   = 4'd0;
        reg_a   = 4'd0;
        reg_b   = 4'd0;
        test_reset();
        test_lda();
        test_ldab_ldb();
        test_exec();
        test_exec_zero();
        test_exec_max();
        test_start_held();
`ifdef CONTROLE_ABORT_EN
        test_abort();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_operacional.md
# controle_operacional

Moore-style sequencer for the 4-bit operand/accumulate datapath: A register (input mux selecting external operand vs. ALU result), B register, and 2-bit-op ALU whose result feeds back into A. It accepts one command per start/done handshake and drives the datapath controls `selA`, `wrA`, `wrB` and `aluOp` cycle by cycle. Multi-cycle `EXEC` applies `A <= A op B` a programmable number of times. It sits between the top-level stimulus (switches/testbench) and the datapath, with one instance per datapath.

## Interface
- `CNT_W`, default 4: width of the repeat-count input and internal down-counter.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: command request; sampled only in IDLE.
- `cmd` in 2: `00` LDA, `01` LDB, `10` LDAB, `11` EXEC.
- `op` in 2: ALU operation code, passed through to `aluOp`.
- `count` in CNT_W: EXEC repeat count.
- `abort` in 1: present only with `CONTROLE_ABORT_EN` (see Configuration).
- `selA` out 1: A-input mux select; 1 = external operand, 0 = ALU result.
- `wrA` out 1: A register write enable.
- `wrB` out 1: B register write enable.
- `aluOp` out 2: ALU operation.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, EXEC, DONE. State, latched `cmd`, `op` register and counter are all registered. Outputs decode from state (Moore).
- IDLE, `start`=1: latch `cmd`, `op` and `count`.
  - LDA/LDB/LDAB: go to LOAD.
  - EXEC with `count`≠0: go to EXEC.
  - EXEC with `count`=0: go directly to DONE. No write occurs.
- IDLE, `start`=0: stay in IDLE.
- LOAD (1 cycle), then DONE:
  - LDA: `selA`=1, `wrA`=1.
  - LDB: `wrB`=1.
  - LDAB: `selA`=1, `wrA`=1, `wrB`=1.
- EXEC:
  - Outputs: `selA`=0, `wrA`=1, `wrB`=0.
  - Counter decrements each cycle; after the cycle with counter=1, go to DONE.
  - Exactly `count` A-writes occur.
- DONE (1 cycle): `done`=1, all write enables 0, then IDLE.
- `aluOp` always equals the `op` register.
  - Updated on every accepted start, whatever the command.
  - Holds its value in IDLE, so `result` stays stable after completion.
- `busy`=1 in LOAD, EXEC and DONE. `start` is ignored while `busy`=1, including during DONE; there is no queuing.
- `cmd`, `op` and `count` changes after acceptance have no effect on the command in flight.
- Outside LOAD/EXEC, `wrA`=`wrB`=`selA`=0.

## Timing
- Reset values: state IDLE, `selA`=0, `wrA`=0, `wrB`=0, `aluOp`=00, `busy`=0, `done`=0, counter=0.
- Reset asserted mid-command: outputs go to reset values immediately (asynchronous). Any write not yet clocked is lost. No `done` is issued.
- Start accepted at edge k:
  - LDA/LDB/LDAB: write enables high in cycle k..k+1. Register captures at edge k+1. `done` high in cycle k+1..k+2. IDLE at edge k+2.
  - EXEC, count N≥1: `wrA` high for N consecutive cycles starting at edge k. `done` high in the cycle after the last write. Start-to-done latency is N+1 cycles.
  - EXEC, count 0: `done` high in cycle k..k+1; latency 1.
- Minimum spacing between accepted starts:
  - Loads: 3 cycles.
  - EXEC: N+2 cycles.
- Maximum EXEC length: 2^CNT_W−1 writes.

## Configuration
- `CONTROLE_ABORT_EN` defined:
  - Adds the `abort` input, sampled synchronously.
  - `abort`=1 in LOAD or EXEC: all write enables drop that same cycle (combinationally gated), and the next state is IDLE. No `done` pulse is issued.
  - `abort` in IDLE or DONE has no effect.
  - `abort` has priority over counter expiry.
- Not defined: no `abort` port; commands always run to completion.

## Test plan
- Reset: assert `reset` mid-cycle with no clock edge → all outputs 0 immediately. Release → stays IDLE, `busy`=0.
- LDA: `start`=1, `cmd`=00, `op`=01 at edge 0 → cycle 0–1 `selA`=1, `wrA`=1, `wrB`=0, `aluOp`=01. `done` in cycle 1–2 only. `busy` low from edge 2.
- LDAB then LDB: LDAB → `wrA`=`wrB`=`selA`=1 for one cycle. Then LDB → only `wrB`=1, `selA`=0. Exactly one `done` per command.
- EXEC: `cmd`=11, `op`=10, `count`=3 → `wrA`=1, `selA`=0, `aluOp`=10 for exactly 3 cycles, `done` on the 4th. With datapath attached, A=1, B=1 and the add encoding: A ends at 4.
- Boundaries:
  - EXEC with `count`=0 → no write enable ever high; `done` one cycle after start.
  - `count`=15 → 15 writes.
  - `start` held high through busy/DONE → second command accepted only on return to IDLE.
- With `CONTROLE_ABORT_EN`: EXEC `count`=5, `abort` at 2nd EXEC cycle → `wrA` high only 1 cycle, then IDLE. No `done`; `busy` low next cycle.
